// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: a word-serial load port fills a cell array,
// and registered fetches assemble cells big-endian with valid/stall/fault.
// Optional alignment fault on fetches: define INSTR_MEM_ALIGN_CHECK_EN.
module instr_mem_loadable #(
  parameter int                     WORD_LEN = 32,
  parameter int                     CELL_W   = 8,
  parameter int                     DEPTH    = 256,
  parameter logic [WORD_LEN-1:0]    NOP_WORD = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_start,
  input  logic                ld_valid,
  input  logic [WORD_LEN-1:0] ld_data,
  input  logic                ld_finish,
  output logic                ld_ready,
  output logic                ld_done,
  input  logic                fetch_req,
  input  logic [WORD_LEN-1:0] fetch_addr,
  input  logic                fetch_stall,
  output logic [WORD_LEN-1:0] instr,
  output logic                instr_valid,
  output logic                addr_fault,
  output logic                busy
);

  localparam int CPW = WORD_LEN / CELL_W;
  localparam int AW  = $clog2(DEPTH);

  // Base address of the last whole word that fits in the array.
  localparam logic [AW-1:0]       LAST_PTR = AW'(DEPTH - CPW);
  localparam logic [WORD_LEN-1:0] MAX_ADDR = WORD_LEN'(DEPTH - CPW);

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [AW-1:0]       ld_ptr, ld_ptr_next;
  logic                ld_done_next;
  logic                wr_en;

  logic [CELL_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       rd_base;
  logic [WORD_LEN-1:0] rd_word;
  logic                out_of_range;
  logic                misaligned;
  logic                fetch_blocked;

  // ---------------------------------------------------------------------------
  // Load FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_next   = state;
    ld_ptr_next  = ld_ptr;
    ld_done_next = 1'b0;
    wr_en        = 1'b0;
    unique case (state)
      RUN: begin
        if (ld_start) begin
          state_next  = LOAD;
          ld_ptr_next = '0;
        end
      end
      LOAD: begin
        wr_en = ld_valid;
        if (ld_valid) ld_ptr_next = ld_ptr + AW'(CPW);
        if (ld_start) begin
          // Restart wins over finish and over the end-of-array condition.
          ld_ptr_next = '0;
        end else if (ld_finish || (ld_valid && (ld_ptr == LAST_PTR))) begin
          state_next   = RUN;
          ld_done_next = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state   <= RUN;
      ld_ptr  <= '0;
      ld_done <= 1'b0;
    end else begin
      state   <= state_next;
      ld_ptr  <= ld_ptr_next;
      ld_done <= ld_done_next;
    end
  end

  assign ld_ready = (state == LOAD);
  assign busy     = (state == LOAD);

  // ---------------------------------------------------------------------------
  // Cell array: written a word at a time, big-endian
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; contents survive rst and only the load port changes them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < CPW; i++) begin
        mem[ld_ptr + AW'(i)] <= ld_data[WORD_LEN-1-i*CELL_W -: CELL_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch path
  // ---------------------------------------------------------------------------
  assign rd_base = fetch_addr[AW-1:0];

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < CPW; i++) begin
      rd_word[WORD_LEN-1-i*CELL_W -: CELL_W] = mem[rd_base + AW'(i)];
    end
  end

  // Compared on the full address so high bits can never alias into the array.
  assign out_of_range = (fetch_addr > MAX_ADDR);

`ifdef INSTR_MEM_ALIGN_CHECK_EN
  assign misaligned = ((fetch_addr % WORD_LEN'(CPW)) != '0);
`else
  assign misaligned = 1'b0;
`endif

  // Fetches are refused while loading and on either transition edge.
  assign fetch_blocked = (state == LOAD) || ld_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
    end else if (!fetch_stall) begin
      if (!fetch_req) begin
        instr_valid <= 1'b0;
        addr_fault  <= 1'b0;
      end else if (fetch_blocked) begin
        instr       <= NOP_WORD;
        instr_valid <= 1'b0;
        addr_fault  <= 1'b0;
      end else if (out_of_range || misaligned) begin
        instr       <= NOP_WORD;
        instr_valid <= 1'b1;
        addr_fault  <= 1'b1;
      end else begin
        instr       <= rd_word;
        instr_valid <= 1'b1;
        addr_fault  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable (32-bit words, 8-bit cells, 16 cells):
// directed scenarios followed by randomized fetch traffic against a byte-array model.
module tb_instr_mem_loadable;

  localparam int WL    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_start, ld_valid, ld_finish;
  logic [WL-1:0] ld_data;
  logic          ld_ready, ld_done;
  logic          fetch_req, fetch_stall;
  logic [WL-1:0] fetch_addr;
  logic [WL-1:0] instr;
  logic          instr_valid, addr_fault, busy;

  int n_checks = 0;
  int n_fail   = 0;

  instr_mem_loadable #(
    .WORD_LEN(WL), .CELL_W(8), .DEPTH(DEPTH), .NOP_WORD('0)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_finish(ld_finish),
    .ld_ready(ld_ready), .ld_done(ld_done),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .instr(instr), .instr_valid(instr_valid), .addr_fault(addr_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: plain byte array plus the response rules.
  typedef struct packed {
    logic [WL-1:0] instr;
    logic          valid;
    logic          fault;
  } resp_t;

  logic [7:0] model_mem [DEPTH];
  int         model_ptr;
  resp_t      exp_r;

  function automatic void model_write(int ptr, logic [WL-1:0] w);
    for (int i = 0; i < 4; i++) model_mem[ptr + i] = w[31 - 8*i -: 8];
  endfunction

  function automatic resp_t model_fetch(logic [WL-1:0] a);
    resp_t r;
    r.instr = '0;
    r.valid = 1'b1;
    r.fault = 1'b0;
    if (a > WL'(DEPTH - 4)) begin
      r.fault = 1'b1;
`ifdef INSTR_MEM_ALIGN_CHECK_EN
    end else if (a[1:0] != 2'b00) begin
      r.fault = 1'b1;
`endif
    end else begin
      r.instr = {model_mem[a], model_mem[a+1], model_mem[a+2], model_mem[a+3]};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [WL-1:0] obs, input logic [WL-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_resp(input string tag, input resp_t r);
    check({tag, ".instr"}, instr, r.instr);
    check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, r.valid});
    check({tag, ".fault"}, {31'd0, addr_fault}, {31'd0, r.fault});
  endtask

  // Random fetch traffic in RUN; the expected response follows the hold/stall rules.
  task automatic rand_fetches(input int n);
    for (int k = 0; k < n; k++) begin
      fetch_req   = ($urandom_range(0, 3) != 0);
      fetch_stall = ($urandom_range(0, 3) == 0);
      fetch_addr  = ($urandom_range(0, 7) == 0) ? WL'($urandom) : WL'($urandom_range(0, 17));
      if (k == 0) begin
        fetch_req   = 1'b1;
        fetch_stall = 1'b0;
      end
      if (!fetch_stall) begin
        if (!fetch_req) begin
          exp_r.valid = 1'b0;
          exp_r.fault = 1'b0;
        end else begin
          exp_r = model_fetch(fetch_addr);
        end
      end
      tick();
      check_resp("rand_fetch", exp_r);
    end
    fetch_req   = 1'b0;
    fetch_stall = 1'b0;
  endtask

  logic [WL-1:0] t1 [4];
  logic [WL-1:0] w0, w1, wr;
  resp_t         r;
  int            guard;

  initial begin
    t1[0] = 32'h3201_0000;
    t1[1] = 32'h1111_2222;
    t1[2] = 32'h0260_0000;
    t1[3] = 32'hDEAD_BEEF;
    rst = 1'b1;
    ld_start = 1'b0; ld_valid = 1'b0; ld_finish = 1'b0; ld_data = '0;
    fetch_req = 1'b0; fetch_stall = 1'b0; fetch_addr = '0;
    model_ptr = 0;

    // Reset state
    tick(); tick();
    check("rst.instr", instr, 32'h0);
    check("rst.valid", {31'd0, instr_valid}, 32'd0);
    check("rst.fault", {31'd0, addr_fault}, 32'd0);
    check("rst.ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst.ld_done", {31'd0, ld_done}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: full load of four words ends on its own
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("t1.busy", {31'd0, busy}, 32'd1);
    check("t1.ld_ready", {31'd0, ld_ready}, 32'd1);
    model_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data  = t1[i];
      model_write(model_ptr, t1[i]);
      model_ptr += 4;
      tick();
      check("t1.ld_done", {31'd0, ld_done}, (i == 3) ? 32'd1 : 32'd0);
      check("t1.busy_during", {31'd0, busy}, (i == 3) ? 32'd0 : 32'd1);
    end
    ld_valid = 1'b0;
    tick();
    check("t1.ld_done_pulse", {31'd0, ld_done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = WL'(4 * i);
      tick();
      check_resp("t1.fetch", model_fetch(fetch_addr));
      check("t1.word", instr, t1[i]);
    end

    // 2: stall holds the response while the address moves
    fetch_addr = 32'd4;
    tick();
    check("t2.first", instr, 32'h1111_2222);
    fetch_stall = 1'b1;
    fetch_addr  = 32'd8;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2.hold_instr", instr, 32'h1111_2222);
      check("t2.hold_valid", {31'd0, instr_valid}, 32'd1);
    end
    fetch_stall = 1'b0;
    tick();
    check("t2.after", instr, 32'h0260_0000);

    // 3: last whole word, idle hold, then out-of-range fetches
    fetch_addr = 32'd12;
    tick();
    check("t3.edge", instr, 32'hDEAD_BEEF);
    fetch_req = 1'b0;
    tick();
    check("t3.idle_instr", instr, 32'hDEAD_BEEF);
    check("t3.idle_valid", {31'd0, instr_valid}, 32'd0);
    fetch_req  = 1'b1;
    fetch_addr = 32'd13;
    tick();
    check_resp("t3.addr13", '{instr: 32'h0, valid: 1'b1, fault: 1'b1});
    fetch_addr = 32'h1000;
    tick();
    check_resp("t3.addr1000", '{instr: 32'h0, valid: 1'b1, fault: 1'b1});

    // 6: unaligned fetch
    fetch_addr = 32'd2;
    tick();
    check_resp("t6.model", model_fetch(32'd2));
`ifdef INSTR_MEM_ALIGN_CHECK_EN
    check_resp("t6.const", '{instr: 32'h0, valid: 1'b1, fault: 1'b1});
`else
    check_resp("t6.const", '{instr: 32'h0000_1111, valid: 1'b1, fault: 1'b0});
`endif
    fetch_req = 1'b0;

    // 4: short load ended by ld_finish; fetches blocked on both transitions
    w0 = WL'($urandom);
    w1 = WL'($urandom);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = w0;
    model_write(0, w0);
    tick();
    ld_data = w1;
    model_write(4, w1);
    tick();
    ld_valid   = 1'b0;
    ld_finish  = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'd0;
    tick();
    check("t4.ld_done", {31'd0, ld_done}, 32'd1);
    check("t4.busy_end", {31'd0, busy}, 32'd0);
    check_resp("t4.fetch_on_finish", '{instr: 32'h0, valid: 1'b0, fault: 1'b0});
    ld_finish = 1'b0;
    ld_start  = 1'b1;
    tick();
    ld_start = 1'b0;
    check("t4.fetch_on_start", {31'd0, instr_valid}, 32'd0);
    check("t4.busy_next", {31'd0, busy}, 32'd1);
    check("t4.ld_done_cleared", {31'd0, ld_done}, 32'd0);
    tick();
    check_resp("t4.fetch_in_load", '{instr: 32'h0, valid: 1'b0, fault: 1'b0});
    fetch_req = 1'b0;
    ld_finish = 1'b1;
    tick();
    ld_finish = 1'b0;
    check("t4.ld_done2", {31'd0, ld_done}, 32'd1);
    fetch_req = 1'b1;
    tick();
    check_resp("t4.w0", model_fetch(32'd0));
    fetch_req = 1'b0;

    // 5: reset mid-load keeps the written word, no done pulse
    wr = WL'($urandom);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = wr;
    model_write(0, wr);
    tick();
    ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5.busy", {31'd0, busy}, 32'd0);
    check("t5.ld_ready", {31'd0, ld_ready}, 32'd0);
    check("t5.ld_done", {31'd0, ld_done}, 32'd0);
    tick();
    check("t5.ld_done_after", {31'd0, ld_done}, 32'd0);
    fetch_req  = 1'b1;
    fetch_addr = 32'd0;
    tick();
    check_resp("t5.kept", model_fetch(32'd0));
    check("t5.word", instr, wr);
    fetch_req = 1'b0;

    // Random: full load with gaps, random fetches, partial reload, more fetches
    ld_start = 1'b1;
    tick();
    ld_start  = 1'b0;
    model_ptr = 0;
    guard     = 0;
    while (model_ptr < DEPTH && guard < 200) begin
      guard++;
      ld_valid = $urandom_range(0, 1);
      ld_data  = WL'($urandom);
      if (ld_valid) begin
        model_write(model_ptr, ld_data);
        model_ptr += 4;
      end
      tick();
      check("rand.load_busy", {31'd0, busy}, (model_ptr == DEPTH) ? 32'd0 : 32'd1);
    end
    ld_valid = 1'b0;
    check("rand.load_done", {31'd0, ld_done}, 32'd1);
    tick();
    rand_fetches(60);

    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = WL'($urandom);
      model_write(4 * i, ld_data);
      tick();
    end
    ld_valid  = 1'b0;
    ld_finish = 1'b1;
    tick();
    ld_finish = 1'b0;
    check("rand.reload_done", {31'd0, ld_done}, 32'd1);
    tick();
    rand_fetches(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised, clocked successor to the fixed combinational instruction memory. It serves instruction fetches from the IF stage with a registered read and a valid/stall handshake.
- Memory is cell-addressed and assembles words big-endian: the lowest address is the MSB cell.
- Contents are written at runtime through a word-serial load port, used by the testbench or boot loader, instead of being hard-coded on reset.

Parameters:
- WORD_LEN, 32, instruction/address width in bits.
- CELL_W, 8, bits per memory cell; WORD_LEN must be a multiple of CELL_W.
- DEPTH, 256, number of cells; power of two, at least WORD_LEN/CELL_W.
- NOP_WORD, 0, value driven on instr for faulted or blocked fetches.
- Derived: CPW = WORD_LEN/CELL_W (cells per word); AW = $clog2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ld_start  in  1  begin program load at cell 0
- ld_valid  in  1  ld_data valid this cycle
- ld_data  in  WORD_LEN  instruction word to store
- ld_finish  in  1  end load early
- ld_ready  out  1  load port accepts a word
- ld_done  out  1  one-cycle pulse when load ends
- fetch_req  in  1  fetch request
- fetch_addr  in  WORD_LEN  cell (byte) address of instruction
- fetch_stall  in  1  hold output registers
- instr  out  WORD_LEN  fetched instruction
- instr_valid  out  1  instr holds a response
- addr_fault  out  1  response was out of range or misaligned
- busy  out  1  load in progress

Behaviour:
- One clock domain: clk, rising edge only. Reset is synchronous and active-high on rst.
- Reset values:
  - state=RUN, ld_ptr=0.
  - ld_ready=0, ld_done=0, busy=0.
  - instr=NOP_WORD, instr_valid=0, addr_fault=0.
  - Memory array is not cleared.
- FSM has two states, RUN and LOAD:
  - RUN→LOAD on ld_start; ld_ptr←0.
  - LOAD→RUN on ld_finish, or when a word is accepted with ld_ptr=DEPTH-CPW. ld_done pulses exactly one cycle, in the cycle after the transition edge.
  - ld_start while in LOAD restarts at ld_ptr=0 with no ld_done pulse.
  - ld_start and ld_finish in the same cycle: ld_start wins.
- Load port:
  - ld_ready=1 iff state=LOAD; busy mirrors this.
  - A word is accepted when ld_valid & ld_ready. The word is written big-endian to cells ld_ptr..ld_ptr+CPW-1, then ld_ptr+=CPW.
  - ld_valid outside LOAD is ignored.
  - The pointer never wraps: the final word accepted at DEPTH-CPW ends the load.
- Fetch, one-cycle latency:
  - In RUN, with fetch_req=1 and fetch_stall=0 at edge N: at edge N+1 instr = {mem[a], mem[a+1], …, mem[a+CPW-1]} with a=fetch_addr[AW-1:0], and instr_valid=1.
  - fetch_req=0 with no stall → instr_valid=0; instr holds its last value.
  - fetch_stall=1 → instr, instr_valid and addr_fault all hold, regardless of fetch_req.
  - Out of range (fetch_addr ≥ DEPTH-CPW+1, checked on full WORD_LEN width): instr=NOP_WORD, instr_valid=1, addr_fault=1. No wrap-around.
  - Fetch in LOAD, or on the LOAD→RUN transition cycle: instr=NOP_WORD, instr_valid=0, addr_fault=0.
  - A word written at edge N is visible to a fetch sampled at edge N+1 or later.
- Reset mid-load: state returns to RUN and ld_ptr=0. Words already written persist. No ld_done pulse.

Optional Feature:
- Macro: INSTR_MEM_ALIGN_CHECK_EN.
- Defined: a fetch with fetch_addr mod CPW ≠ 0 returns instr=NOP_WORD, instr_valid=1, addr_fault=1. Range checking is unchanged.
- Undefined: no alignment check; unaligned addresses assemble cells a..a+CPW-1 as normal, and only the range fault exists.

Test Plan (WORD_LEN=32, CELL_W=8, DEPTH=16 unless stated):
1. Load four words 0x3201_0000, 0x1111_2222, 0x0260_0000, 0xDEAD_BEEF back to back. Then fetch addresses 0, 4, 8, 12.
   - ld_done pulses once, after the 4th word, with no ld_finish.
   - The four words return in order, each one cycle after its request; addr_fault=0.
2. Fetch 4 with fetch_stall held high for 3 cycles, while fetch_addr changes to 8.
   - instr stays 0x1111_2222 and instr_valid stays 1 until stall drops.
   - The next cycle returns 0x0260_0000.
3. Fetch address 13, then address 0x1000.
   - Both responses: instr=0x0000_0000, addr_fault=1, instr_valid=1.
4. Load two words, assert ld_finish, then fetch 0 in the same cycle as ld_start.
   - ld_done pulses.
   - The fetch response is instr_valid=0; busy=1 the following cycle.
5. Assert rst after 1 of 3 load words.
   - busy=0, ld_ready=0, no ld_done.
   - Fetch 0 returns the word written before reset.
6. With INSTR_MEM_ALIGN_CHECK_EN defined, fetch address 2.
   - addr_fault=1, instr=0.
   - Without the macro: instr={mem[2],mem[3],mem[4],mem[5]}=0x0000_1111, addr_fault=0.
